// File: rtl/systolic_collector.sv
// De-skews the bottom-edge column sums of the PE grid into aligned rows,
// tags each row with its index in the matrix and buffers rows in a small FIFO.
module systolic_collector #(
  parameter int DATA_WIDTH = 4,
  parameter int SUM_WIDTH  = DATA_WIDTH * DATA_WIDTH,
  parameter int COLS       = 4,
  parameter int NUM_ROWS   = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int W  = COLS * SUM_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [W-1:0]  in_sum,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [RW-1:0] out_row,
  output logic          out_last,
  output logic          overflow,
  input  logic          clr_ovf
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]    row_w;
  logic [COLS-2:0] vld_q;
  logic            av;

  // Column c lags column 0 by c cycles, so it needs COLS-1-c stages.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_pass
      assign row_w[c*SUM_WIDTH +: SUM_WIDTH] = in_sum[c*SUM_WIDTH +: SUM_WIDTH];
    end else begin : g_dly
      logic [SUM_WIDTH-1:0] sr_q [D];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < D; i++) sr_q[i] <= '0;
        end else begin
          sr_q[0] <= in_sum[c*SUM_WIDTH +: SUM_WIDTH];
          for (int i = 1; i < D; i++) sr_q[i] <= sr_q[i-1];
        end
      end
      assign row_w[c*SUM_WIDTH +: SUM_WIDTH] = sr_q[D-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_q <= '0;
    else        vld_q <= (vld_q << 1) | (COLS-1)'(in_valid);
  end

  assign av = vld_q[COLS-2];

  logic [W-1:0]  dat_q [FIFO_DEPTH];
  logic [RW-1:0] tag_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic          ovf_q, ovf_d;
  logic          pop, push, drop, full;

  always_comb begin
    pop   = out_valid & out_ready;
    full  = (cnt_q == CW'(FIFO_DEPTH));
    push  = av & (~full | pop);
    drop  = av & full & ~pop;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    row_d = row_q;
    ovf_d = ovf_q;
    if (push) begin
      wr_d  = wr_q + AW'(1);
      row_d = (row_q == RW'(NUM_ROWS - 1)) ? '0 : row_q + RW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
    // A drop in the same cycle as a clear must still be reported.
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      row_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        dat_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (push) begin
      dat_q[wr_q] <= row_w;
      tag_q[wr_q] <= row_q;
    end
  end

  assign out_valid = (cnt_q != '0);
  assign out_data  = dat_q[rd_q];
  assign out_row   = tag_q[rd_q];
  assign out_last  = (tag_q[rd_q] == RW'(NUM_ROWS - 1));
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_systolic_collector.sv
// Bench for systolic_collector: skewed column driver plus a queue-based
// model of the aligned-row FIFO, row tags and sticky overflow.
module tb_systolic_collector;

  localparam int SW   = 16;
  localparam int COLS = 4;
  localparam int NR   = 4;
  localparam int D    = 4;
  localparam int W    = COLS * SW;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_sum = '0;
  logic         out_ready = 1'b0;
  logic         clr_ovf = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_row;
  logic         out_last;
  logic         overflow;

  systolic_collector #(
    .DATA_WIDTH(4), .SUM_WIDTH(SW), .COLS(COLS),
    .NUM_ROWS(NR), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_sum(in_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row),
    .out_last(out_last), .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; logic [W-1:0] r; } slot_t;
  typedef struct { logic [W-1:0] r; int tag; } ent_t;

  slot_t hist [COLS];
  ent_t  mq [$];
  int    popped [$];
  int    tag_m;
  bit    ovf_m;
  int    n_chk;
  int    n_fail;

  logic         s_valid;
  logic         s_last;
  logic         s_ovf;
  logic [1:0]   s_row;
  logic [W-1:0] s_data;

  task automatic clear_model();
    for (int k = 0; k < COLS; k++) begin
      hist[k].v = 1'b0;
      hist[k].r = '0;
    end
    mq.delete();
    popped.delete();
    tag_m = 0;
    ovf_m = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    in_sum = '0;
    out_ready = 1'b0;
    clr_ovf = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  function automatic logic [W-1:0] rnd_row();
    logic [W-1:0] r;
    for (int c = 0; c < COLS; c++) r[c*SW +: SW] = SW'($urandom);
    return r;
  endfunction

  // One clock cycle: drive skewed columns, check outputs, advance the model.
  task automatic cyc(input bit v, input logic [W-1:0] r,
                     input bit rdy, input bit clr);
    bit pop;
    bit drop;
    ent_t e;
    for (int k = COLS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0].v = v;
    hist[0].r = r;
    in_valid = v;
    out_ready = rdy;
    clr_ovf = clr;
    for (int c = 0; c < COLS; c++) in_sum[c*SW +: SW] = hist[c].r[c*SW +: SW];
    @(negedge clk);
    s_valid = out_valid;
    s_data = out_data;
    s_row = out_row;
    s_last = out_last;
    s_ovf = overflow;
    n_chk++;
    if (out_valid !== (mq.size() != 0)) begin
      n_fail++;
      $display("FAIL out_valid: got %b want %b", out_valid, mq.size() != 0);
    end
    n_chk++;
    if (overflow !== ovf_m) begin
      n_fail++;
      $display("FAIL overflow: got %b want %b", overflow, ovf_m);
    end
    if (mq.size() != 0) begin
      n_chk++;
      if (out_data !== mq[0].r || out_row !== 2'(mq[0].tag) ||
          out_last !== (mq[0].tag == NR - 1)) begin
        n_fail++;
        $display("FAIL head: got data=%h row=%0d last=%b want data=%h row=%0d last=%b",
                 out_data, out_row, out_last, mq[0].r, mq[0].tag, mq[0].tag == NR - 1);
      end
    end
    pop = (mq.size() != 0) && rdy;
    drop = 1'b0;
    @(posedge clk);
    if (pop) begin
      popped.push_back(mq[0].tag);
      mq.delete(0);
    end
    if (hist[COLS-1].v) begin
      if (mq.size() < D) begin
        e.r = hist[COLS-1].r;
        e.tag = tag_m;
        mq.push_back(e);
        tag_m = (tag_m + 1) % NR;
      end else begin
        drop = 1'b1;
        ovf_m = 1'b1;
      end
    end
    if (clr && !drop) ovf_m = 1'b0;
    #1;
  endtask

  task automatic check_popped(input string nm, input int exp_q [$]);
    n_chk++;
    if (popped.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s count: got %0d want %0d", nm, popped.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_chk++;
        if (popped[i] != exp_q[i]) begin
          n_fail++;
          $display("FAIL %s[%0d]: got %0d want %0d", nm, i, popped[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if ({out_valid, out_data, out_row, out_last, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_init: got v=%b d=%h r=%0d l=%b o=%b want all 0",
               out_valid, out_data, out_row, out_last, overflow);
    end
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, rnd_row(), 1'b0, 1'b0);
    repeat (4) cyc(1'b0, '0, 1'b0, 1'b0);
    n_chk++;
    if (s_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prefill: got out_valid=%b want 1", s_valid);
    end
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, out_data, out_row, out_last, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got v=%b d=%h r=%0d l=%b o=%b want all 0",
               out_valid, out_data, out_row, out_last, overflow);
    end
    clear_model();
    in_valid = 1'b0;
    in_sum = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0);
      n_chk++;
      if (s_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: got out_valid=%b want 0", s_valid);
      end
    end
    cyc(1'b1, rnd_row(), 1'b1, 1'b0);
    repeat (5) cyc(1'b0, '0, 1'b1, 1'b0);
    check_popped("reset_rows", '{0});
  endtask

  task automatic test_single();
    logic [W-1:0] r;
    logic [W-1:0] exp_d;
    do_reset();
    for (int c = 0; c < COLS; c++) r[c*SW +: SW] = SW'(10 * (c + 1));
    exp_d = {16'd40, 16'd30, 16'd20, 16'd10};
    cyc(1'b1, r, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      if (k == 3) begin
        n_chk++;
        if (s_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL single_early: got out_valid=%b want 0", s_valid);
        end
      end
      if (k == 4) begin
        n_chk++;
        if (s_valid !== 1'b1 || s_data !== exp_d || s_row !== 2'd0 || s_last !== 1'b0) begin
          n_fail++;
          $display("FAIL single_row: got v=%b d=%h r=%0d l=%b want v=1 d=%h r=0 l=0",
                   s_valid, s_data, s_row, s_last, exp_d);
        end
      end
    end
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_stream();
    logic [SW-1:0] vals [4];
    logic [W-1:0]  r;
    logic [9:0]    vseq;
    vals[0] = 16'hFFFF;
    vals[1] = 16'hFFF8;
    vals[2] = 16'h7FFF;
    vals[3] = 16'h8000;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k < 4) begin
        for (int c = 0; c < COLS; c++) r[c*SW +: SW] = vals[(k + c) % 4];
        cyc(1'b1, r, 1'b1, 1'b0);
      end else begin
        cyc(1'b0, '0, 1'b1, 1'b0);
      end
      vseq[k] = s_valid;
    end
    n_chk++;
    if (vseq !== 10'b0011110000) begin
      n_fail++;
      $display("FAIL stream_gaps: got %b want %b", vseq, 10'b0011110000);
    end
    check_popped("stream_rows", '{0, 1, 2, 3});
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, rnd_row(), 1'b0, 1'b0);
    repeat (4) cyc(1'b0, '0, 1'b0, 1'b0);
    n_chk++;
    if (s_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_overflow: got %b want 1", s_ovf);
    end
    cyc(1'b1, rnd_row(), 1'b0, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    n_chk++;
    if (s_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_set_wins: got %b want 1", s_ovf);
    end
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0);
    check_popped("bp_rows", '{0, 1, 2, 3});
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    n_chk++;
    if (s_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_clear: got %b want 0", s_ovf);
    end
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, rnd_row(), 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, rnd_row(), 1'b0, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    n_chk++;
    if (s_ovf !== 1'b0 || s_row !== 2'd1 || s_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_simul: got ovf=%b row=%0d v=%b want ovf=0 row=1 v=1",
               s_ovf, s_row, s_valid);
    end
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0);
    check_popped("full_rows", '{0, 1, 2, 3, 0});
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1'b1, rnd_row(), 1'b1, 1'b0);
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0);
    check_popped("wrap_rows", '{0, 1, 2, 3, 0, 1, 2, 3, 0});
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), rnd_row(),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
    end
    repeat (10) cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    clear_model();
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_full_simul();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
